// File: rtl/mcu_datapath_pkg.sv
// Shared constants for the MCU core: widths, ALU function codes, opcodes
// and APSR flag positions, plus the immediate-form opcode classifier.
package mcu_datapath_pkg;

  localparam int INST_WIDTH  = 8;
  localparam int APSR_WIDTH  = 3;
  localparam int ALUOP_WIDTH = 4;

  // Bit positions inside the status register
  localparam int ZERO     = 0;
  localparam int CARRY    = 1;
  localparam int NEGATIVE = 2;

  typedef logic [ALUOP_WIDTH-1:0] aluop_t;
  typedef logic [INST_WIDTH-1:0]  opcode_t;

  localparam aluop_t ALU_NOP  = 4'd0;
  localparam aluop_t ALU_ADD  = 4'd1;
  localparam aluop_t ALU_ADDC = 4'd2;
  localparam aluop_t ALU_SUB  = 4'd3;
  localparam aluop_t ALU_SUBC = 4'd4;
  localparam aluop_t ALU_NAND = 4'd5;
  localparam aluop_t ALU_NOR  = 4'd6;
  localparam aluop_t ALU_XOR  = 4'd7;
  localparam aluop_t ALU_XNOR = 4'd8;

  localparam opcode_t MCU_LOAD   = 8'h00;
  localparam opcode_t MCU_LOADI  = 8'h01;
  localparam opcode_t MCU_STORE  = 8'h02;
  localparam opcode_t MCU_STOREI = 8'h03;
  localparam opcode_t MCU_ADD    = 8'h04;
  localparam opcode_t MCU_ADDI   = 8'h05;
  localparam opcode_t MCU_ADDC   = 8'h06;
  localparam opcode_t MCU_ADDCI  = 8'h07;
  localparam opcode_t MCU_SUB    = 8'h08;
  localparam opcode_t MCU_SUBI   = 8'h09;
  localparam opcode_t MCU_SUBC   = 8'h0A;
  localparam opcode_t MCU_SUBCI  = 8'h0B;
  localparam opcode_t MCU_NAND   = 8'h0C;
  localparam opcode_t MCU_NANDI  = 8'h0D;
  localparam opcode_t MCU_NOR    = 8'h0E;
  localparam opcode_t MCU_NORI   = 8'h0F;
  localparam opcode_t MCU_XOR    = 8'h10;
  localparam opcode_t MCU_XORI   = 8'h11;
  localparam opcode_t MCU_XNOR   = 8'h12;
  localparam opcode_t MCU_XNORI  = 8'h13;
  localparam opcode_t MCU_JMP    = 8'h14;
  localparam opcode_t MCU_JZ     = 8'h15;
  localparam opcode_t MCU_JC     = 8'h16;
  localparam opcode_t MCU_JN     = 8'h17;

  // Opcodes whose operand is the immediate word rather than a RAM location
  function automatic logic is_imm_op(input opcode_t op);
    logic hit;
    hit = 1'b0;
    case (op)
      MCU_LOADI, MCU_STOREI, MCU_ADDI, MCU_ADDCI, MCU_SUBI,
      MCU_SUBCI, MCU_NANDI, MCU_NORI, MCU_XORI, MCU_XNORI: hit = 1'b1;
      default: hit = 1'b0;
    endcase
    return hit;
  endfunction

endpackage

// File: rtl/mcu_datapath_alu.sv
// Combinational ALU: arithmetic through a DATA_WIDTH+1 bit sum so the top
// bit is the carry; logical ops clear carry. Unknown codes report !known.
module mcu_alu
  import mcu_datapath_pkg::*;
#(
  parameter int DATA_WIDTH = 8
) (
  input  logic [ALUOP_WIDTH-1:0] op,
  input  logic [DATA_WIDTH-1:0]  a,
  input  logic [DATA_WIDTH-1:0]  b,
  input  logic                   carry_in,
  output logic [DATA_WIDTH-1:0]  result,
  output logic [APSR_WIDTH-1:0]  flags,
  output logic                   known
);

  localparam logic [DATA_WIDTH:0] SUM_ONE = (DATA_WIDTH + 1)'(1);

  logic [DATA_WIDTH:0] a_ext;
  logic [DATA_WIDTH:0] b_ext;
  logic [DATA_WIDTH:0] nb_ext;
  logic [DATA_WIDTH:0] c_ext;
  logic [DATA_WIDTH:0] sum;
  logic                carry_out;

  assign a_ext  = {1'b0, a};
  assign b_ext  = {1'b0, b};
  assign nb_ext = {1'b0, ~b};
  assign c_ext  = {{DATA_WIDTH{1'b0}}, carry_in};

  // Select the function; SUB is acc + ~op + 1 so carry set means no borrow
  always_comb begin
    sum       = '0;
    result    = '0;
    carry_out = 1'b0;
    known     = 1'b1;
    case (op)
      ALU_ADD: begin
        sum       = a_ext + b_ext;
        result    = sum[DATA_WIDTH-1:0];
        carry_out = sum[DATA_WIDTH];
      end
      ALU_ADDC: begin
        sum       = a_ext + b_ext + c_ext;
        result    = sum[DATA_WIDTH-1:0];
        carry_out = sum[DATA_WIDTH];
      end
      ALU_SUB: begin
        sum       = a_ext + nb_ext + SUM_ONE;
        result    = sum[DATA_WIDTH-1:0];
        carry_out = sum[DATA_WIDTH];
      end
      ALU_SUBC: begin
        sum       = a_ext + nb_ext + c_ext;
        result    = sum[DATA_WIDTH-1:0];
        carry_out = sum[DATA_WIDTH];
      end
      ALU_NAND: result = ~(a & b);
      ALU_NOR:  result = ~(a | b);
      ALU_XOR:  result = a ^ b;
      ALU_XNOR: result = ~(a ^ b);
      default:  known  = 1'b0;
    endcase
  end

  // Pack the status flags derived from the result
  always_comb begin
    flags           = '0;
    flags[ZERO]     = (result == '0);
    flags[CARRY]    = carry_out;
    flags[NEGATIVE] = result[DATA_WIDTH-1];
  end

endmodule

// File: rtl/mcu_datapath_ram.sv
// Data RAM: synchronous write, combinational read (old data on same-cycle
// read of the word being written). Contents are deliberately not reset.
module mcu_ram #(
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [DATA_WIDTH-1:0] wdata,
  output logic [DATA_WIDTH-1:0] rdata
);

  logic [DATA_WIDTH-1:0] mem [0:(1<<ADDR_WIDTH)-1];

  // Write port
  always_ff @(posedge clk) begin
    if (we) begin
      mem[addr] <= wdata;
    end
  end

  assign rdata = mem[addr];

endmodule

// File: rtl/mcu_datapath.sv
// Execution datapath of the MCU core: PC, immediate, shadow opcode, data
// RAM, ALU, result/flag staging, accumulator and status register.
module mcu_datapath
  import mcu_datapath_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [INST_WIDTH-1:0]  imem_data,
  input  logic                   opcode_update,
  input  logic                   imm_update,
  input  logic                   pc_count,
  input  logic                   pc_load,
  input  logic                   ram_write,
  input  logic [ALUOP_WIDTH-1:0] alu_operation,
  input  logic                   acc_update,
  input  logic                   psr_update,
  output logic [ADDR_WIDTH-1:0]  imem_addr,
  output logic [APSR_WIDTH-1:0]  apsr,
  output logic [DATA_WIDTH-1:0]  acc
);

  localparam logic [ADDR_WIDTH-1:0] PC_ONE = ADDR_WIDTH'(1);

  logic [ADDR_WIDTH-1:0] pc;
  logic [ADDR_WIDTH-1:0] pc_plus1;
  logic [DATA_WIDTH-1:0] imm;
  logic [INST_WIDTH-1:0] op_q;
  logic [DATA_WIDTH-1:0] res;
  logic [APSR_WIDTH-1:0] flg;
  logic [APSR_WIDTH-1:0] psr;

  logic [DATA_WIDTH-1:0] ram_rdata;
  logic [DATA_WIDTH-1:0] operand;
  logic [DATA_WIDTH-1:0] alu_result;
  logic [APSR_WIDTH-1:0] alu_flags;
  logic                  alu_known;
  logic                  is_load;

  assign pc_plus1  = pc + PC_ONE;
  assign imem_addr = imm_update ? pc_plus1 : pc;
  assign operand   = is_imm_op(op_q) ? imm : ram_rdata;
  assign is_load   = (op_q == MCU_LOAD) || (op_q == MCU_LOADI);
  assign apsr      = psr_update ? flg : psr;

  mcu_ram #(
    .ADDR_WIDTH(ADDR_WIDTH),
    .DATA_WIDTH(DATA_WIDTH)
  ) u_ram (
    .clk  (clk),
    .we   (ram_write & ~rst),
    .addr (imm[ADDR_WIDTH-1:0]),
    .wdata(acc),
    .rdata(ram_rdata)
  );

  mcu_alu #(
    .DATA_WIDTH(DATA_WIDTH)
  ) u_alu (
    .op      (alu_operation),
    .a       (acc),
    .b       (operand),
    .carry_in(psr[CARRY]),
    .result  (alu_result),
    .flags   (alu_flags),
    .known   (alu_known)
  );

  // Fetch-side registers: shadow opcode, immediate word and program counter
  always_ff @(posedge clk) begin
    if (rst) begin
      op_q <= MCU_LOAD;
      imm  <= '0;
      pc   <= '0;
    end else begin
      if (opcode_update) op_q <= imem_data;
      if (imm_update)    imm  <= imem_data[DATA_WIDTH-1:0];
      if (pc_load)       pc   <= imm[ADDR_WIDTH-1:0];
      else if (pc_count) pc   <= pc_plus1;
    end
  end

  // Result staging: ALU result and flags, a loaded operand, or a copy of acc
  always_ff @(posedge clk) begin
    if (rst) begin
      res <= '0;
      flg <= '0;
    end else if (alu_known) begin
      res <= alu_result;
      flg <= alu_flags;
    end else if (is_load) begin
      res <= operand;
    end else begin
      res <= acc;
    end
  end

  // Architectural commit of accumulator and status register
  always_ff @(posedge clk) begin
    if (rst) begin
      acc <= '0;
      psr <= '0;
    end else begin
      if (acc_update) acc <= res;
      if (psr_update) psr <= flg;
    end
  end

endmodule

// File: tb/tb_mcu_datapath.sv
// Bench for mcu_datapath: plays the MCU sequencer over a small directed
// program and checks pc, acc and apsr through a scoreboard queue.
module tb_mcu_datapath;
  import mcu_datapath_pkg::*;

  typedef struct {
    logic [7:0] addr;
    logic [7:0] op;
    logic [7:0] arg;
    bit         taken;
    bit         both;
    logic [7:0] expPc;
    logic [7:0] expAcc;
    logic [2:0] expPsr;
  } vec_t;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] imem_data;
  logic       opcode_update, imm_update, pc_count, pc_load, ram_write;
  logic [3:0] alu_operation;
  logic       acc_update, psr_update;
  logic [7:0] imem_addr;
  logic [2:0] apsr;
  logic [7:0] acc;

  logic [7:0]  imem [0:255];
  logic [7:0]  pcQ [$];
  logic [10:0] stQ [$];
  vec_t        prog [$];
  logic        execCheck, postCheck;
  bit          pending;
  int          total = 0;
  int          bad = 0;

  mcu_datapath dut (
    .clk          (clk),
    .rst          (rst),
    .imem_data    (imem_data),
    .opcode_update(opcode_update),
    .imm_update   (imm_update),
    .pc_count     (pc_count),
    .pc_load      (pc_load),
    .ram_write    (ram_write),
    .alu_operation(alu_operation),
    .acc_update   (acc_update),
    .psr_update   (psr_update),
    .imem_addr    (imem_addr),
    .apsr         (apsr),
    .acc          (acc)
  );

  always #5 clk = ~clk;

  assign imem_data = imem[imem_addr];

  task automatic checkOutput(input string name, input logic [15:0] actual, input logic [15:0] expected);
    total++;
    if (actual !== expected) begin
      bad++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, actual, expected, $time);
    end
  endtask

  function automatic logic [3:0] aluFor(input logic [7:0] op);
    case (op)
      MCU_ADD,  MCU_ADDI:  return ALU_ADD;
      MCU_ADDC, MCU_ADDCI: return ALU_ADDC;
      MCU_SUB,  MCU_SUBI:  return ALU_SUB;
      MCU_SUBC, MCU_SUBCI: return ALU_SUBC;
      MCU_NAND, MCU_NANDI: return ALU_NAND;
      MCU_NOR,  MCU_NORI:  return ALU_NOR;
      MCU_XOR,  MCU_XORI:  return ALU_XOR;
      MCU_XNOR, MCU_XNORI: return ALU_XNOR;
      default:             return ALU_NOP;
    endcase
  endfunction

  function automatic bit isJump(input logic [7:0] op);
    return (op == MCU_JMP) || (op == MCU_JZ) || (op == MCU_JC) || (op == MCU_JN);
  endfunction

  task automatic addVec(input logic [7:0] addr, input logic [7:0] op, input logic [7:0] arg,
                        input bit taken, input bit both, input logic [7:0] expPc,
                        input logic [7:0] expAcc, input logic [2:0] expPsr);
    vec_t v;
    v.addr = addr; v.op = op; v.arg = arg; v.taken = taken; v.both = both;
    v.expPc = expPc; v.expAcc = expAcc; v.expPsr = expPsr;
    prog.push_back(v);
  endtask

  task automatic nextCycle();
    @(posedge clk);
    #1;
    opcode_update = 1'b0; imm_update = 1'b0; pc_count = 1'b0; pc_load = 1'b0;
    ram_write = 1'b0; alu_operation = ALU_NOP; acc_update = 1'b0; psr_update = 1'b0;
    execCheck = 1'b0; postCheck = 1'b0;
  endtask

  // One instruction as the MCU sequences it: FETCH, DECODE, EXECUTE
  task automatic applyStimulus(input vec_t v);
    nextCycle();
    imm_update = 1'b1;
    pc_count   = 1'b1;
    postCheck  = pending;
    nextCycle();
    if (isJump(v.op) && v.taken) begin
      pc_load  = 1'b1;
      pc_count = v.both;
    end else begin
      pc_count = 1'b1;
    end
    alu_operation = aluFor(v.op);
    ram_write     = (v.op == MCU_STORE);
    pcQ.push_back(v.expPc);
    nextCycle();
    acc_update    = !isJump(v.op) && (v.op != MCU_STORE) && (v.op != MCU_STOREI);
    psr_update    = (aluFor(v.op) != ALU_NOP);
    opcode_update = 1'b1;
    execCheck     = 1'b1;
    stQ.push_back({v.expPsr, v.expAcc});
    pending = 1'b1;
  endtask

  // Scoreboard monitor: pop and compare whenever the sequencer flags a check point
  always @(negedge clk) begin
    if (execCheck) begin
      if (pcQ.size() == 0) checkOutput("pc_queue_empty", 16'd1, 16'd0);
      else checkOutput("imem_addr", {8'h00, imem_addr}, {8'h00, pcQ.pop_front()});
    end
    if (postCheck) begin
      if (stQ.size() == 0) checkOutput("state_queue_empty", 16'd1, 16'd0);
      else begin
        logic [10:0] e;
        e = stQ.pop_front();
        checkOutput("acc", {8'h00, acc}, {8'h00, e[7:0]});
        checkOutput("apsr", {13'h0, apsr}, {13'h0, e[10:8]});
      end
    end
  end

  // Watchdog so a stuck run still reports and ends
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  // Main sequence: reset checks, then the directed program
  initial begin
    rst = 1'b1;
    opcode_update = 1'b0; imm_update = 1'b0; pc_count = 1'b0; pc_load = 1'b0;
    ram_write = 1'b0; alu_operation = ALU_NOP; acc_update = 1'b0; psr_update = 1'b0;
    execCheck = 1'b0; postCheck = 1'b0; pending = 1'b0;
    for (int i = 0; i < 256; i++) imem[i] = 8'h00;

    addVec(8'h00, MCU_LOADI, 8'h7F, 0, 0, 8'h02, 8'h7F, 3'b000);
    addVec(8'h02, MCU_ADDI,  8'h01, 0, 0, 8'h04, 8'h80, 3'b100);
    addVec(8'h04, MCU_LOADI, 8'hFF, 0, 0, 8'h06, 8'hFF, 3'b100);
    addVec(8'h06, MCU_ADDI,  8'h01, 0, 0, 8'h08, 8'h00, 3'b011);
    addVec(8'h08, MCU_ADDCI, 8'h00, 0, 0, 8'h0A, 8'h01, 3'b000);
    addVec(8'h0A, MCU_LOADI, 8'h5A, 0, 0, 8'h0C, 8'h5A, 3'b000);
    addVec(8'h0C, MCU_STORE, 8'h10, 0, 0, 8'h0E, 8'h5A, 3'b000);
    addVec(8'h0E, MCU_LOADI, 8'h00, 0, 0, 8'h10, 8'h00, 3'b000);
    addVec(8'h10, MCU_LOAD,  8'h10, 0, 0, 8'h12, 8'h5A, 3'b000);
    addVec(8'h12, MCU_SUBI,  8'h5A, 0, 0, 8'h14, 8'h00, 3'b011);
    addVec(8'h14, MCU_JZ,    8'h20, 1, 0, 8'h20, 8'h00, 3'b011);
    addVec(8'h20, MCU_SUBI,  8'h01, 0, 0, 8'h22, 8'hFF, 3'b100);
    addVec(8'h22, MCU_JZ,    8'h40, 0, 0, 8'h24, 8'hFF, 3'b100);
    addVec(8'h24, MCU_XORI,  8'h0F, 0, 0, 8'h26, 8'hF0, 3'b100);
    addVec(8'h26, MCU_NANDI, 8'hF0, 0, 0, 8'h28, 8'h0F, 3'b000);
    addVec(8'h28, MCU_ADDI,  8'hF1, 0, 0, 8'h2A, 8'h00, 3'b011);
    addVec(8'h2A, MCU_SUBCI, 8'h00, 0, 0, 8'h2C, 8'h00, 3'b011);
    addVec(8'h2C, MCU_ADD,   8'h10, 0, 0, 8'h2E, 8'h5A, 3'b000);
    addVec(8'h2E, MCU_NORI,  8'h0F, 0, 0, 8'h30, 8'hA0, 3'b100);
    addVec(8'h30, MCU_JMP,   8'h33, 1, 1, 8'h33, 8'hA0, 3'b100);
    addVec(8'h33, MCU_XNORI, 8'hA0, 0, 0, 8'h35, 8'hFF, 3'b100);
    addVec(8'h35, MCU_JMP,   8'hFE, 1, 0, 8'hFE, 8'hFF, 3'b100);
    addVec(8'hFE, MCU_ADDCI, 8'h01, 0, 0, 8'h00, 8'h00, 3'b011);

    foreach (prog[i]) begin
      logic [7:0] a1;
      a1 = prog[i].addr + 8'd1;
      imem[prog[i].addr] = prog[i].op;
      imem[a1]           = prog[i].arg;
    end

    $display("[TB] reset with random strobes");
    for (int i = 0; i < 2; i++) begin
      nextCycle();
      opcode_update = 1'($urandom_range(0, 1));
      imm_update    = 1'($urandom_range(0, 1));
      pc_count      = 1'($urandom_range(0, 1));
      pc_load       = 1'($urandom_range(0, 1));
      ram_write     = 1'($urandom_range(0, 1));
      alu_operation = 4'($urandom_range(0, 15));
      acc_update    = 1'($urandom_range(0, 1));
      psr_update    = 1'($urandom_range(0, 1));
    end
    nextCycle();
    pcQ.push_back(8'h00);
    stQ.push_back(11'h000);
    execCheck = 1'b1;
    postCheck = 1'b1;
    @(negedge clk);
    #1;
    checkOutput("reset_op_q", {8'h00, dut.op_q}, {8'h00, MCU_LOAD});
    checkOutput("reset_pc", {8'h00, dut.pc}, 16'h0000);

    nextCycle();
    rst           = 1'b0;
    acc_update    = 1'b1;
    psr_update    = 1'b1;
    opcode_update = 1'b1;

    $display("[TB] running directed program of %0d instructions", prog.size());
    foreach (prog[i]) applyStimulus(prog[i]);

    nextCycle();
    postCheck = pending;
    nextCycle();
    checkOutput("pc_queue_leftover", 16'(pcQ.size()), 16'd0);
    checkOutput("state_queue_leftover", 16'(stQ.size()), 16'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
